// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: fetch/decode and decode/execute pipeline records,
// ALU and writeback selectors, base opcodes and a few decode helpers.
package riscv_pkg;

  localparam int unsigned Xlen    = 32;
  localparam int unsigned NumRegs = 32;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
    AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_t;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;   // operand A is pc (AUIPC, JAL target)
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    wb_sel_t     wb_sel;
    logic        branch;
    logic        jump;
  } id_ex_t;

  // Empty pipeline slot carrying the given NOP encoding.
  function automatic id_ex_t bubble(logic [31:0] nop);
    id_ex_t b;
    b       = '0;
    b.instr = nop;
    return b;
  endfunction

  // Register/immediate ALU ops; alt selects SUB/SRA (instr[30]).
  function automatic alu_op_t alu_from_funct(logic [2:0] funct3, logic alt);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // Branch compare: EQ/NE by subtraction, LT/GE signed, LTU/GEU unsigned.
  function automatic alu_op_t alu_from_branch(logic [2:0] funct3);
    alu_op_t op;
    unique case (funct3[2:1])
      2'b10:   op = AluSlt;
      2'b11:   op = AluSltu;
      default: op = AluSub;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two combinational read ports with write-through
// bypass, one write port. x0 is hardwired to zero. Contents are not reset.
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [Xlen-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [Xlen-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [Xlen-1:0] rdata_b
);

  logic [Xlen-1:0] regs [NumRegs];
  logic            wr_en;

  assign wr_en = we && (waddr != 5'd0);

  // Write port; x0 is never stored.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the index is forwarded.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (raddr_a == 5'd0) begin
      rdata_a = '0;
    end else if (wr_en && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if (raddr_b == 5'd0) begin
      rdata_b = '0;
    end else if (wr_en && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, control decode, immediate generation,
// load-use hazard detection and the registered ID/EX pipeline record.
module id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  if_id_t      in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output id_ex_t      out,
  output logic        stall_req
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2;
  id_ex_t      dec;
  id_ex_t      out_q;

  assign instr  = in.instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  regfile u_regfile (
    .clk     (clk),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .rdata_a (rs1_data),
    .raddr_b (rs2),
    .rdata_b (rs2_data)
  );

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Control decode of the incoming instruction; unknown opcodes become illegal.
  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = in_valid;
    dec.instr    = instr;
    dec.pc       = in.pc;
    dec.pcplus4  = in.pcplus4;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rd       = rd;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.funct3   = funct3;
    dec.alu_op   = AluAdd;
    dec.wb_sel   = WbAlu;
    case (opcode)
      OpLui: begin
        dec.imm         = imm_u;
        dec.alu_op      = AluPassB;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OpAuipc: begin
        dec.imm         = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.alu_src_pc  = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OpJal: begin
        dec.imm         = imm_j;
        dec.alu_src_imm = 1'b1;
        dec.alu_src_pc  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.wb_sel      = WbPc4;
        dec.jump        = 1'b1;
      end
      OpJalr: begin
        use_rs1         = 1'b1;
        dec.imm         = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
        dec.wb_sel      = WbPc4;
        dec.jump        = 1'b1;
      end
      OpBranch: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.imm    = imm_b;
        dec.alu_op = alu_from_branch(funct3);
        dec.branch = 1'b1;
      end
      OpLoad: begin
        use_rs1         = 1'b1;
        dec.imm         = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.wb_sel      = WbMem;
      end
      OpStore: begin
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        dec.imm         = imm_s;
        dec.alu_src_imm = 1'b1;
        dec.mem_write   = 1'b1;
      end
      OpImm: begin
        use_rs1         = 1'b1;
        dec.imm         = imm_i;
        // instr[30] is immediate data except for SRAI
        dec.alu_op      = alu_from_funct(funct3, (funct3 == 3'b101) && instr[30]);
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OpReg: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.alu_op    = alu_from_funct(funct3, instr[30]);
        dec.reg_write = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Load-use hazard: the load in out cannot forward to the instruction behind it.
  always_comb begin
    stall_req = out_q.valid && out_q.mem_read && (out_q.rd != 5'd0) && in_valid &&
                ((use_rs1 && (rs1 == out_q.rd)) || (use_rs2 && (rs2 == out_q.rd)));
  end

  // Pipeline register: reset/flush/hazard insert a bubble, stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= bubble(NOP_INSTR);
    end else if (flush) begin
      out_q <= bubble(NOP_INSTR);
    end else if (stall) begin
      out_q <= out_q;
    end else if (stall_req) begin
      out_q <= bubble(NOP_INSTR);
    end else begin
      out_q <= dec;
    end
  end

  assign out = out_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction word encoded in every inserted bubble.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in  input  if_id_t  fetched instr, pc, pcplus4 from fetch.
REQ-005 SHALL have port in_valid  input  1  in carries a real instruction.
REQ-006 SHALL have port stall  input  1  downstream hold; freeze out.
REQ-007 SHALL have port flush  input  1  redirect taken; discard the current decode.
REQ-008 SHALL have port wb_we  input  1  writeback register write enable.
REQ-009 SHALL have port wb_rd  input  5  writeback destination index.
REQ-010 SHALL have port wb_data  input  32  writeback value.
REQ-011 SHALL have port out  output  id_ex_t  registered decode result to execute.
REQ-012 SHALL have port stall_req  output  1  load-use hazard; fetch must hold pc and in.

Function
REQ-013 SHALL hold a 32x32 register file; x0 reads 0 and ignores writes.
REQ-014 SHALL write wb_data to wb_rd at a clock edge when wb_we=1 and wb_rd!=0.
REQ-015 SHALL read rs1 (instr[19:15]) and rs2 (instr[24:20]) combinationally, returning wb_data when wb_we=1, wb_rd!=0 and the index matches (write-through bypass).
REQ-016 SHALL decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP into out control fields: alu_op, alu_src_imm, mem_read, mem_write, reg_write, wb_sel, branch, jump, funct3, and rd/rs1/rs2 indices.
REQ-017 SHALL generate the I, S, B, U and J immediates, sign-extended from instr[31] to 32 bits; B and J bit 0 forced 0.
REQ-018 SHALL flag any other opcode with out.illegal=1, reg_write=0, mem_read=0, mem_write=0 and valid=1.
REQ-019 SHALL assert stall_req combinationally when out.valid, out.mem_read, out.rd!=0, and out.rd equals an rs1 or rs2 the incoming instruction uses, with in_valid=1.
REQ-020 SHALL update out per edge with priority: rst, then flush (load a bubble), then stall (hold), then stall_req (load a bubble), then capture the decode of in with valid=in_valid.
REQ-021 SHALL give each bubble valid=0, all control enables 0, instr=NOP_INSTR, and all other fields 0.
REQ-022 SHALL have a capture latency of exactly one cycle, in to out.
REQ-023 SHALL let register file writes proceed during stall, flush and stall_req.

Reset
REQ-024 SHALL load out with a bubble on the first edge with rst=1, and SHALL hold stall_req at 0 while out is a bubble.
REQ-025 SHALL NOT clear register file contents on rst; a bench initialises them through the write port.
REQ-026 SHALL discard any in-flight decode when rst is asserted mid-stream, with out a bubble on the next edge.

Structure
REQ-027 SHALL place if_id_t, id_ex_t, alu_op_t, wb_sel_t and the opcode localparams in shared package riscv_pkg.
REQ-028 SHALL implement the register file as sub-module regfile (2 read ports, 1 write port, with bypass); decode and immediate logic stay inline.

Verification
REQ-029 SHALL cover this case: write x5=32'hDEAD_BEEF, then decode ADD x1,x5,x0 -> next cycle out.rs1_data=32'hDEAD_BEEF, alu_op=ADD, reg_write=1.
REQ-030 SHALL cover this case: wb_we=1, wb_rd=7, wb_data=32'h1234 in the same cycle as decoding ADDI x2,x7,-1 -> out.rs1_data=32'h1234, out.imm=32'hFFFF_FFFF.
REQ-031 SHALL cover this case: LW x3,0(x1) followed by ADD x4,x3,x3 -> stall_req=1 for one cycle, bubble on out, then the ADD is captured.
REQ-032 SHALL cover this case: flush=1 together with stall=1 -> out becomes a bubble (flush wins).
REQ-033 SHALL cover this case: BEQ with offset -4096 -> out.imm=32'hFFFF_F000, and a write to x0 followed by a read returns 0.
REQ-034 SHALL cover this case: opcode 7'b1111111 -> out.illegal=1, out.reg_write=0; and rst mid-stream -> out.valid=0 next cycle.
